// File: rtl/triumph_pkg.sv
// Shared types for the triumph RV32I pipeline: ALU operations, opcodes, operand selects,
// the decoded-instruction record and immediate extraction helpers.
package triumph_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11,
    ALU_LT   = 4'd12,
    ALU_GE   = 4'd13,
    ALU_LTU  = 4'd14,
    ALU_GEU  = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] OP_A_RS1  = 2'd0;
  localparam logic [1:0] OP_A_PC   = 2'd1;
  localparam logic [1:0] OP_A_ZERO = 2'd2;

  localparam logic OP_B_RS2 = 1'b0;
  localparam logic OP_B_IMM = 1'b1;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic [1:0]  op_a_sel;
    logic        op_b_sel;
    logic        rd_we;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jump;
    logic        illegal;
  } decode_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{21{instr[31]}}, instr[30:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{21{instr[31]}}, instr[30:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // alt selects SUB/SRA (instr[30]) where the encoding has an alternate form
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/triumph_decoder.sv
// Purely combinational RV32I decoder: instruction word to register addresses, immediate
// and control fields. Illegal encodings keep only the register addresses and raise illegal.
module triumph_decoder
  import triumph_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;
  decode_t    d;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    d          = '0;
    d.rs1      = instr[19:15];
    d.rs2      = instr[24:20];
    d.rd       = instr[11:7];
    d.alu_op   = ALU_ADD;
    d.op_a_sel = OP_A_RS1;
    d.op_b_sel = OP_B_RS2;
    illegal    = 1'b0;

    case (opcode)
      OPC_LUI: begin
        d.imm      = imm_u(instr);
        d.op_a_sel = OP_A_ZERO;
        d.op_b_sel = OP_B_IMM;
        d.rd_we    = 1'b1;
      end
      OPC_AUIPC: begin
        d.imm      = imm_u(instr);
        d.op_a_sel = OP_A_PC;
        d.op_b_sel = OP_B_IMM;
        d.rd_we    = 1'b1;
      end
      OPC_JAL: begin
        d.imm      = imm_j(instr);
        d.op_a_sel = OP_A_PC;
        d.op_b_sel = OP_B_IMM;
        d.rd_we    = 1'b1;
        d.jump     = 1'b1;
      end
      OPC_JALR: begin
        d.imm      = imm_i(instr);
        d.op_a_sel = OP_A_PC;
        d.op_b_sel = OP_B_IMM;
        d.rd_we    = 1'b1;
        d.jump     = 1'b1;
        illegal    = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d.imm    = imm_b(instr);
        d.branch = 1'b1;
        case (funct3)
          3'b000:  d.alu_op = ALU_EQ;
          3'b001:  d.alu_op = ALU_NE;
          3'b100:  d.alu_op = ALU_LT;
          3'b101:  d.alu_op = ALU_GE;
          3'b110:  d.alu_op = ALU_LTU;
          3'b111:  d.alu_op = ALU_GEU;
          default: illegal  = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.imm      = imm_i(instr);
        d.op_b_sel = OP_B_IMM;
        d.rd_we    = 1'b1;
        d.mem_req  = 1'b1;
        d.mem_size = funct3;
        illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        d.imm      = imm_s(instr);
        d.op_b_sel = OP_B_IMM;
        d.mem_req  = 1'b1;
        d.mem_we   = 1'b1;
        d.mem_size = funct3;
        illegal    = (funct3[2] == 1'b1) || (funct3 == 3'b011);
      end
      OPC_OP_IMM: begin
        // shift-immediates reuse imm[11:5] as funct7; only SRAI may set bit 30
        d.imm      = imm_i(instr);
        d.op_b_sel = OP_B_IMM;
        d.rd_we    = 1'b1;
        d.alu_op   = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)
          illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        d.rd_we  = 1'b1;
        d.alu_op = alu_from_funct3(funct3, funct7[5]);
        if (funct7 == 7'h20)
          illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
        else
          illegal = (funct7 != 7'h00);
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        // FENCE and SYSTEM retire as NOPs in this core
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      d         = '0;
      d.rs1     = instr[19:15];
      d.rs2     = instr[24:20];
      d.rd      = instr[11:7];
      d.illegal = 1'b1;
    end

    if (d.rd == 5'd0)
      d.rd_we = 1'b0;
  end

  assign dec = d;

endmodule

// File: rtl/triumph_id_stage.sv
// RV32I decode stage: combinational decode feeding the ID/EX register, with a valid/ready
// handshake toward EX, back-pressure toward IF and a flush from branch resolution.
module triumph_id_stage
  import triumph_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_data_i,
  input  logic [XLEN-1:0] instr_pc_i,
  output logic            id_ready_o,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] imm_o,
  output logic [3:0]      alu_op_o,
  output logic [1:0]      op_a_sel_o,
  output logic            op_b_sel_o,
  output logic            rd_we_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [2:0]      mem_size_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            illegal_o
);

  decode_t         dec;
  decode_t         dec_q;
  logic            ex_valid_q;
  logic [XLEN-1:0] ex_pc_q;
  logic            id_ready;

  triumph_decoder u_decoder (
    .instr (instr_data_i),
    .dec   (dec)
  );

  assign id_ready = ex_ready_i | ~ex_valid_q;

  // Flush wins over everything but reset; payload is only written on an accepted load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= RESET_PC;
      dec_q      <= '0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (id_ready) begin
      ex_valid_q <= instr_valid_i;
      if (instr_valid_i) begin
        dec_q   <= dec;
        ex_pc_q <= instr_pc_i;
      end
    end
  end

  assign id_ready_o = id_ready;
  assign ex_valid_o = ex_valid_q;
  assign ex_pc_o    = ex_pc_q;
  assign rs1_addr_o = dec_q.rs1;
  assign rs2_addr_o = dec_q.rs2;
  assign rd_addr_o  = dec_q.rd;
  assign imm_o      = dec_q.imm;
  assign alu_op_o   = dec_q.alu_op;
  assign op_a_sel_o = dec_q.op_a_sel;
  assign op_b_sel_o = dec_q.op_b_sel;
  assign rd_we_o    = dec_q.rd_we;
  assign mem_req_o  = dec_q.mem_req;
  assign mem_we_o   = dec_q.mem_we;
  assign mem_size_o = dec_q.mem_size;
  assign branch_o   = dec_q.branch;
  assign jump_o     = dec_q.jump;
  assign illegal_o  = dec_q.illegal;

endmodule

// File: tb/tb_triumph_id_stage.sv
// Self-checking bench for triumph_id_stage: directed scenarios plus randomized traffic
// checked against an instruction-level reference model of the ID/EX register.
module tb_triumph_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  // alu codes by funct3 for OP/OP-IMM and BRANCH, four bits per entry, entry 0 in the low bits
  localparam logic [31:0] OP_ALU = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};
  localparam logic [31:0] BR_ALU = {4'd15, 4'd14, 4'd13, 4'd12, 4'd0, 4'd0, 4'd11, 4'd10};
  localparam logic [76:0] OPS = {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic        rd_we;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jump;
    logic        illegal;
  } out_t;

  logic        clk_i = 1'b0;
  logic        rst_i, instr_valid_i, flush_i, ex_ready_i;
  logic [31:0] instr_data_i, instr_pc_i;
  logic        id_ready_o, ex_valid_o;
  logic [31:0] ex_pc_o, imm_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [3:0]  alu_op_o;
  logic [1:0]  op_a_sel_o;
  logic        op_b_sel_o, rd_we_o, mem_req_o, mem_we_o, branch_o, jump_o, illegal_o;
  logic [2:0]  mem_size_o;

  out_t obs;
  out_t model;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  triumph_id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_data_i  (instr_data_i),
    .instr_pc_i    (instr_pc_i),
    .id_ready_o    (id_ready_o),
    .flush_i       (flush_i),
    .ex_ready_i    (ex_ready_i),
    .ex_valid_o    (ex_valid_o),
    .ex_pc_o       (ex_pc_o),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rd_addr_o     (rd_addr_o),
    .imm_o         (imm_o),
    .alu_op_o      (alu_op_o),
    .op_a_sel_o    (op_a_sel_o),
    .op_b_sel_o    (op_b_sel_o),
    .rd_we_o       (rd_we_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_size_o    (mem_size_o),
    .branch_o      (branch_o),
    .jump_o        (jump_o),
    .illegal_o     (illegal_o)
  );

  assign obs = {ex_valid_o, ex_pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o, imm_o, alu_op_o,
                op_a_sel_o, op_b_sel_o, rd_we_o, mem_req_o, mem_we_o, mem_size_o,
                branch_o, jump_o, illegal_o};

  // Reference decode built from the ISA tables: immediates assembled arithmetically
  function automatic out_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    out_t r;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    logic [31:0] sx, iimm, simm, bimm, jimm, uimm;
    r = '0; r.valid = 1'b1; r.pc = pc;
    r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; ok = 1'b1;
    sx   = w[31] ? 32'hFFFF_FFFF : 32'h0;
    iimm = (sx & 32'hFFFF_F800) | 32'(w[30:20]);
    simm = (sx & 32'hFFFF_F800) | (32'(w[30:25]) << 5) | 32'(w[11:7]);
    bimm = (sx & 32'hFFFF_F000) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    jimm = (sx & 32'hFFF0_0000) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    uimm = w & 32'hFFFF_F000;
    case (op)
      7'h37: begin r.imm = uimm; r.a_sel = 2; r.b_sel = 1; r.rd_we = 1; end
      7'h17: begin r.imm = uimm; r.a_sel = 1; r.b_sel = 1; r.rd_we = 1; end
      7'h6F: begin r.imm = jimm; r.a_sel = 1; r.b_sel = 1; r.rd_we = 1; r.jump = 1; end
      7'h67: begin
        ok = (f3 == 0);
        r.imm = iimm; r.a_sel = 1; r.b_sel = 1; r.rd_we = 1; r.jump = 1;
      end
      7'h63: begin
        ok = !(f3 == 2 || f3 == 3);
        r.imm = bimm; r.branch = 1; r.alu = BR_ALU[f3*4 +: 4];
      end
      7'h03: begin
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        r.imm = iimm; r.b_sel = 1; r.rd_we = 1; r.mem_req = 1; r.mem_size = f3;
      end
      7'h23: begin
        ok = (f3 < 3);
        r.imm = simm; r.b_sel = 1; r.mem_req = 1; r.mem_we = 1; r.mem_size = f3;
      end
      7'h13: begin
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
        r.imm = iimm; r.b_sel = 1; r.rd_we = 1;
        r.alu = OP_ALU[f3*4 +: 4] + ((f3 == 5 && f7 == 7'h20) ? 4'd1 : 4'd0);
      end
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        r.rd_we = 1;
        r.alu = OP_ALU[f3*4 +: 4] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
      end
      7'h0F, 7'h73: ;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r.imm = 0; r.alu = 0; r.a_sel = 0; r.b_sel = 0; r.rd_we = 0; r.mem_req = 0;
      r.mem_we = 0; r.mem_size = 0; r.branch = 0; r.jump = 0; r.illegal = 1;
    end
    if (r.rd == 0) r.rd_we = 1'b0;
    return r;
  endfunction

  // One clock with the current inputs; the model follows the handshake rules
  task automatic step();
    out_t nm;
    nm = model;
    if (rst_i) begin
      nm = '0; nm.pc = RST_PC;
    end else if (flush_i) begin
      nm.valid = 1'b0;
    end else if (ex_ready_i || !model.valid) begin
      if (instr_valid_i) nm = ref_decode(instr_data_i, instr_pc_i);
      else nm.valid = 1'b0;
    end
    @(posedge clk_i);
    model = nm;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    instr_valid_i = v; instr_data_i = w; instr_pc_i = pc; ex_ready_i = rdy; flush_i = fl;
  endtask

  task automatic test_reset();
    out_t exp_rst;
    exp_rst = '0; exp_rst.pc = RST_PC;
    rst_i = 1'b1;
    drive(1'b1, 32'h0050_0093, 32'h44, 1'b1, 1'b0);
    step(); step();
    total++;
    if (obs !== exp_rst) begin
      bad++; $display("FAIL reset_state: got %h want %h", obs, exp_rst);
    end
    total++;
    if (id_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", id_ready_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h0050_0093, 32'h10, 1'b1, 1'b0);
    step();
    total++;
    if ({ex_valid_o, rd_addr_o, rs1_addr_o, imm_o, alu_op_o, op_b_sel_o, rd_we_o, ex_pc_o}
        !== {1'b1, 5'd1, 5'd0, 32'd5, 4'd0, 1'b1, 1'b1, 32'h10}) begin
      bad++;
      $display("FAIL addi: got v=%b rd=%0d rs1=%0d imm=%h alu=%0d b=%b we=%b pc=%h want 1 1 0 5 0 1 1 10",
               ex_valid_o, rd_addr_o, rs1_addr_o, imm_o, alu_op_o, op_b_sel_o, rd_we_o, ex_pc_o);
    end
  endtask

  task automatic test_beq_lui();
    drive(1'b1, 32'hFE00_0EE3, 32'h14, 1'b1, 1'b0);
    step();
    total++;
    if ({imm_o, branch_o, alu_op_o, rd_we_o, illegal_o} !== {32'hFFFF_FFFC, 1'b1, 4'd10, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL beq: got imm=%h br=%b alu=%0d we=%b ill=%b want fffffffc 1 10 0 0",
               imm_o, branch_o, alu_op_o, rd_we_o, illegal_o);
    end
    drive(1'b1, 32'h1234_5137, 32'h18, 1'b1, 1'b0);
    step();
    total++;
    if ({imm_o, op_a_sel_o, op_b_sel_o, rd_addr_o, rd_we_o} !== {32'h1234_5000, 2'd2, 1'b1, 5'd2, 1'b1}) begin
      bad++;
      $display("FAIL lui: got imm=%h a=%0d b=%b rd=%0d we=%b want 12345000 2 1 2 1",
               imm_o, op_a_sel_o, op_b_sel_o, rd_addr_o, rd_we_o);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h0050_0093, 32'h10, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h1234_5137, 32'h20, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (id_ready_o !== 1'b0) begin
        bad++; $display("FAIL stall_ready: cycle %0d got %b want 0", i, id_ready_o);
      end
      step();
      total++;
      if ({ex_valid_o, rd_addr_o, imm_o, ex_pc_o} !== {1'b1, 5'd1, 32'd5, 32'h10}) begin
        bad++;
        $display("FAIL stall_hold: cycle %0d got v=%b rd=%0d imm=%h pc=%h want 1 1 5 10",
                 i, ex_valid_o, rd_addr_o, imm_o, ex_pc_o);
      end
    end
    ex_ready_i = 1'b1;
    #1;
    total++;
    if (id_ready_o !== 1'b1) begin
      bad++; $display("FAIL release_ready: got %b want 1", id_ready_o);
    end
    step();
    total++;
    if ({ex_valid_o, rd_addr_o, imm_o, ex_pc_o, op_a_sel_o} !== {1'b1, 5'd2, 32'h1234_5000, 32'h20, 2'd2}) begin
      bad++;
      $display("FAIL release_load: got v=%b rd=%0d imm=%h pc=%h a=%0d want 1 2 12345000 20 2",
               ex_valid_o, rd_addr_o, imm_o, ex_pc_o, op_a_sel_o);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0050_0093, 32'h30, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h1234_5137, 32'h34, 1'b0, 1'b1);
    step();
    total++;
    if (ex_valid_o !== 1'b0) begin
      bad++; $display("FAIL flush: ex_valid got %b want 0", ex_valid_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    total++;
    if (id_ready_o !== 1'b1) begin
      bad++; $display("FAIL flush_ready: got %b want 1", id_ready_o);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words [2];
    words[0] = 32'hFFFF_FFFF; words[1] = 32'h0000_0000;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, words[i], 32'h40 + 32'(i * 4), 1'b1, 1'b0);
      step();
      total++;
      if ({illegal_o, rd_we_o, mem_req_o, branch_o, jump_o, ex_valid_o} !== 6'b100001) begin
        bad++;
        $display("FAIL illegal_%h: got ill=%b we=%b mem=%b br=%b j=%b v=%b want 1 0 0 0 0 1",
                 words[i], illegal_o, rd_we_o, mem_req_o, branch_o, jump_o, ex_valid_o);
      end
    end
    drive(1'b1, 32'h0020_8033, 32'h48, 1'b1, 1'b0);
    step();
    total++;
    if ({rd_we_o, illegal_o, ex_valid_o, rd_addr_o} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
      bad++;
      $display("FAIL add_x0: got we=%b ill=%b v=%b rd=%0d want 0 0 1 0",
               rd_we_o, illegal_o, ex_valid_o, rd_addr_o);
    end
  endtask

  task automatic test_reset_in_stall();
    out_t exp_rst;
    exp_rst = '0; exp_rst.pc = RST_PC;
    drive(1'b1, 32'h0050_0093, 32'h50, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h1234_5137, 32'h54, 1'b0, 1'b0);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    total++;
    if (obs !== exp_rst) begin
      bad++; $display("FAIL reset_in_stall: got %h want %h", obs, exp_rst);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    int k;
    for (int n = 0; n < 800; n++) begin
      k = $urandom_range(0, 11);
      w = $urandom;
      if (k < 11) begin
        w[6:0] = OPS[k*7 +: 7];
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: ;
        endcase
      end
      rst_i = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0, w, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0);
      #1;
      total++;
      if (id_ready_o !== (ex_ready_i | ~model.valid)) begin
        bad++;
        $display("FAIL rand_ready: iter %0d got %b want %b", n, id_ready_o, ex_ready_i | ~model.valid);
      end
      step();
      total++;
      if (obs !== model) begin
        bad++;
        $display("FAIL rand_out: iter %0d instr %h got %h want %h", n, w, obs, model);
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_addi();
    test_beq_lui();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_in_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
